pipeline_stage_ctrl: RTL and testbench
======================================

Name: pipeline_stage_ctrl

Overview:
- Valid/ready controller for one CPU pipeline stage register (IF/ID, ID/EX, ...); owns a main and a skid N-bit register bank.
- Decouples producer and consumer stages so the upstream stall path (in_ready) is purely registered; supports a flush from the hazard/branch unit.
- Sits between two pipeline stages; the team's FlipFlop register primitive, or equivalent always blocks, may hold the banks.

Parameters:
- N, 32, width in bits of the stage payload (in_data/out_data).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream presents in_data this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  N  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  N  payload from the main register.
- occupancy  output  2  number of held entries (0, 1 or 2).

Behaviour:
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- State machine has three states:
  - EMPTY (occupancy 0): in_ready=1, out_valid=0.
  - ONE (occupancy 1, main full): in_ready=1, out_valid=1.
  - TWO (occupancy 2, main and skid full): in_ready=0, out_valid=1.
- Outputs in_ready, out_valid and occupancy depend only on state; there is no combinational path from any input to any output except out_data, which is driven by the main register.
- Transitions when flush=0:
  - EMPTY: on in_valid, main<=in_data and go to ONE; otherwise stay.
  - ONE, in_valid & out_ready: main<=in_data, stay ONE (full throughput).
  - ONE, in_valid & !out_ready: skid<=in_data, go to TWO; main is unchanged.
  - ONE, !in_valid & out_ready: go to EMPTY.
  - ONE, !in_valid & !out_ready: hold.
  - TWO, out_ready: main<=skid, go to ONE; in_valid is ignored because in_ready=0.
  - TWO, !out_ready: hold; main and skid are unchanged.
- Latency: an entry accepted at edge t is on out_data with out_valid=1 after edge t, one cycle later.
- Throughput: 1 entry/cycle while out_ready=1.
- Ordering is strict FIFO; no entry is ever dropped or duplicated unless flushed.
- Flush (synchronous, highest priority):
  - Next state is EMPTY; main<=0, skid<=0.
  - A simultaneous input transfer (in_valid & in_ready) is discarded.
  - A simultaneous output transfer still counts as consumed by downstream.
  - flush while already EMPTY has no effect beyond clearing the registers.
- Reset (asynchronous):
  - On assertion, immediately: state=EMPTY, main=0, skid=0, so in_ready=1, out_valid=0, out_data=0, occupancy=0.
  - Reset mid-operation loses all entries.
  - The first transfer is possible at the first rising edge after deassertion.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Data width: payload is passed bit-exact; no arithmetic on data. occupancy is unsigned and never encodes 3.

Test Plan:
- Reset: assert reset mid-cycle with state TWO -> immediately occupancy=0, out_valid=0, in_ready=1, out_data=0; no clock edge required.
- Streaming: out_ready=1, push 0x00000001..0x00000005 on consecutive cycles -> each appears on out_data exactly one cycle after acceptance; occupancy stays 1 during streaming; in_ready never drops.
- Backpressure/skid: out_ready=0, push 0xAAAAAAAA then 0x55555555 -> occupancy=2, in_ready=0, out_data holds 0xAAAAAAAA. A third in_valid (0xDEADBEEF) is not accepted. Raise out_ready -> outputs 0xAAAAAAAA, 0x55555555, then 0xDEADBEEF, in order.
- Flush with simultaneous input: in state TWO, assert flush with in_valid=1 and in_data=0x12345678 -> next cycle occupancy=0, out_valid=0, out_data=0; 0x12345678 never appears at the output.
- Drain to empty: in ONE holding 0xFFFFFFFF, in_valid=0 and out_ready=1 -> after the edge, state EMPTY, out_valid=0. Next push 0x0 is output after 1 cycle.
- Randomized scoreboard: random in_valid/out_ready for 1000 cycles with no flush -> output sequence equals input sequence exactly, and out_data is stable whenever out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/pipeline_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_ctrl
// Description : Valid/ready controller for one CPU pipeline stage register.
//               Holds up to two entries (main + skid) so the upstream stall
//               signal in_ready is a pure function of registered state.
//               A synchronous flush discards all held entries.
// Ports       : clk        - pipeline clock, rising-edge active
//               reset      - asynchronous active-high reset
//               flush      - synchronous flush, highest priority
//               in_valid   - upstream presents in_data
//               in_ready   - stage can accept an entry this cycle
//               in_data    - upstream payload (N bits)
//               out_valid  - out_data holds a valid entry
//               out_ready  - downstream accepts out_data this cycle
//               out_data   - payload from the main register (N bits)
//               occupancy  - number of held entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    // State encoding equals the entry count, so occupancy is the state itself.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]   r_state;
    logic [N-1:0] r_main;
    logic [N-1:0] r_skid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // Any simultaneous input is dropped; an output handshake in the
            // same cycle was already taken by downstream.
            r_state <= c_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (in_valid) begin
                        r_main  <= in_data;
                        r_state <= c_ONE;
                    end
                end
                c_ONE: begin
                    if (in_valid && out_ready) begin
                        r_main <= in_data;
                    end else if (in_valid) begin
                        // Downstream stalled: park the new entry in the skid
                        // register, main keeps the older one in front.
                        r_skid  <= in_data;
                        r_state <= c_TWO;
                    end else if (out_ready) begin
                        r_state <= c_EMPTY;
                    end
                end
                c_TWO: begin
                    // in_ready is low here, so in_valid is irrelevant.
                    if (out_ready) begin
                        r_main  <= r_skid;
                        r_state <= c_ONE;
                    end
                end
                default: begin
                    r_state <= c_EMPTY;
                end
            endcase
        end
    end

    // All handshake outputs are decoded from registered state only.
    assign in_ready  = (r_state != c_TWO);
    assign out_valid = (r_state != c_EMPTY);
    assign occupancy = r_state;
    assign out_data  = r_main;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stage_ctrl
// Description : Self-checking bench for pipeline_stage_ctrl. A queue holds
//               the entries the stage should currently contain; handshake
//               outputs and out_data are compared against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_ctrl;

    localparam int c_N = 32;

    logic           clk;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [c_N-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [c_N-1:0] out_data;
    logic [1:0]     occupancy;

    pipeline_stage_ctrl #(.N(c_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             r_vec_cnt = 0;
    int             r_err_cnt = 0;
    logic [c_N-1:0] r_q[$];
    logic           r_zero_exp = 1'b0;
    logic           r_hold_prev = 1'b0;
    logic [c_N-1:0] r_hold_data = '0;

    task automatic chk(input string tag, input logic [c_N-1:0] got, input logic [c_N-1:0] exp);
        r_vec_cnt++;
        if (got !== exp) begin
            r_err_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: called at a falling edge, drives inputs, checks the
    // state-derived outputs against the queue, advances the model, then
    // waits for the next falling edge.
    task automatic cycle(input logic iv, input logic [c_N-1:0] id, input logic ordy, input logic fl);
        logic m_ready;
        logic m_valid;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        m_ready = (r_q.size() < 2);
        m_valid = (r_q.size() > 0);
        chk("occupancy", {30'd0, occupancy}, c_N'(r_q.size()));
        chk("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) chk("out_data", out_data, r_q[0]);
        if (r_zero_exp) chk("out_data_zero", out_data, '0);
        if (r_hold_prev) chk("stable", out_data, r_hold_data);
        r_hold_prev = m_valid && !ordy;
        r_hold_data = out_data;
        if (m_valid && ordy) void'(r_q.pop_front());
        if (fl) begin
            r_q.delete();
            r_zero_exp  = 1'b1;
            r_hold_prev = 1'b0;
        end else if (iv && m_ready) begin
            r_q.push_back(id);
            r_zero_exp = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [c_N-1:0] v_data;
        logic           v_pend;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset takes effect with no clock edge involved.
        #1 reset = 1'b1;
        #1;
        chk("rst_occ",   {30'd0, occupancy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        r_zero_exp = 1'b1;

        // Streaming with downstream always ready.
        for (int k = 1; k <= 5; k++) cycle(1'b1, c_N'(k), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure into the skid register; third entry must wait.
        cycle(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
        cycle(1'b1, 32'h55555555, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in TWO with a simultaneous input offer.
        cycle(1'b1, 32'h11111111, 1'b0, 1'b0);
        cycle(1'b1, 32'h22222222, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345678, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Drain to empty, then a zero payload.
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle while in TWO.
        cycle(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        cycle(1'b1, 32'hBADC0FFE, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_occ",   {30'd0, occupancy}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data",  out_data, 32'd0);
        #1 reset = 1'b0;
        r_q.delete();
        r_zero_exp  = 1'b1;
        r_hold_prev = 1'b0;
        @(negedge clk);
        cycle(1'b1, 32'h0BADF00D, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Random traffic; producer holds an offered entry until accepted.
        v_pend = 1'b0;
        v_data = '0;
        for (int i = 0; i < 1000; i++) begin
            logic v_iv;
            logic v_acc;
            if (!v_pend) begin
                v_pend = ($urandom_range(0, 3) != 0);
                v_data = $urandom;
            end
            v_iv  = v_pend;
            v_acc = v_iv && (r_q.size() < 2);
            cycle(v_iv, v_data, ($urandom_range(0, 2) != 0), 1'b0);
            if (v_acc) v_pend = 1'b0;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", r_vec_cnt, r_err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
